// File: rtl/fccc_reconfig_pkg.sv
// Shared types for the FCCC/CCC PLL reconfiguration sequencer.
// State encoding, error codes and APB field widths of the CCC configuration port.
package fccc_reconfig_pkg;

  localparam int CFG_ADDR_W = 6;
  localparam int CFG_DATA_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST,
    ST_WR_SETUP,
    ST_WR_ACCESS,
    ST_RD_SETUP,
    ST_RD_ACCESS,
    ST_NEXT,
    ST_WAIT_BUSY,
    ST_RELEASE,
    ST_WAIT_LOCK,
    ST_LOCKED,
    ST_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_VERIFY  = 2'b01;
  localparam logic [1:0] ERR_BUSY_TO = 2'b10;
  localparam logic [1:0] ERR_LOCK_TO = 2'b11;

endpackage

// File: rtl/fccc_lock_qual.sv
// LOCK qualifier: 2-flop synchronizer, consecutive-high stable counter, timeout counter.
// lock_s lags ccc_lock by 2 cycles; counters saturate at their limits, no backpressure.
module fccc_lock_qual #(
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lock_async,
  input  logic clear,
  input  logic run,
  output logic lock_s,
  output logic lock_ok,
  output logic lock_to
);

  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(LOCK_STABLE);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(LOCK_TIMEOUT);

  logic          lock_meta;
  logic [SW-1:0] stable_cnt;
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= lock_async;
      lock_s    <= lock_meta;
    end
  end

  // Any low sample of the synchronized lock restarts the stability window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
    end else if (clear || !lock_s) begin
      stable_cnt <= '0;
    end else if (stable_cnt != STABLE_MAX) begin
      stable_cnt <= stable_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (clear) begin
      to_cnt <= '0;
    end else if (run && to_cnt != TIMEOUT_MAX) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  assign lock_ok = (stable_cnt == STABLE_MAX);
  assign lock_to = (to_cnt == TIMEOUT_MAX);

endmodule

// File: rtl/fccc_reconfig_ctrl.sv
// Sequencer that holds the PLL in reset, writes/verifies the config table over APB, then qualifies LOCK.
// Fixed 2-cycle APB transfers (no PREADY); all outputs registered and aligned with the state.
module fccc_reconfig_ctrl
  import fccc_reconfig_pkg::*;
#(
  parameter int NUM_ENTRIES  = 8,
  parameter int ENTRY_W      = 3,
  parameter int RST_CYCLES   = 16,
  parameter int BUSY_TIMEOUT = 256,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int VERIFY       = 1
) (
  input  logic                             PCLK,
  input  logic                             PRESET_N,
  input  logic                             start,
  input  logic                             clr,
  output logic [ENTRY_W-1:0]               cfg_idx,
  input  logic [CFG_ADDR_W+CFG_DATA_W-1:0] cfg_word,
  output logic                             PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [CFG_ADDR_W-1:0]            PADDR,
  output logic [CFG_DATA_W-1:0]            PWDATA,
  input  logic [CFG_DATA_W-1:0]            PRDATA,
  input  logic                             ccc_busy,
  input  logic                             ccc_lock,
  output logic                             PLL_ARST_N,
  output logic                             ctl_busy,
  output logic                             done,
  output logic                             err,
  output logic [1:0]                       err_code,
  output logic                             lock_lost
);

  localparam int CNT_LIM = (RST_CYCLES > BUSY_TIMEOUT) ? RST_CYCLES : BUSY_TIMEOUT;
  localparam int CW      = $clog2(CNT_LIM + 1);
  localparam logic [CW-1:0]      RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]      BUSY_LAST = CW'(BUSY_TIMEOUT - 1);
  localparam logic [ENTRY_W-1:0] IDX_LAST  = ENTRY_W'(NUM_ENTRIES - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            last_entry;
  logic            lock_s, lock_ok, lock_to;
  logic            restart, to_next, qual_clr, fail;
  logic [1:0]      fail_code;
  logic [CFG_ADDR_W-1:0] cfg_addr;
  logic [CFG_DATA_W-1:0] cfg_data;

  assign cfg_addr = cfg_word[CFG_ADDR_W+CFG_DATA_W-1:CFG_DATA_W];
  assign cfg_data = cfg_word[CFG_DATA_W-1:0];

  assign restart  = start && (state == ST_IDLE || state == ST_LOCKED || state == ST_ERROR);
  assign to_next  = (state == ST_WR_ACCESS && VERIFY == 0) ||
                    (state == ST_RD_ACCESS && PRDATA == cfg_data);
  assign qual_clr = (state == ST_RELEASE) || (state == ST_LOCKED && !lock_s);

  always_comb begin
    fail      = 1'b0;
    fail_code = ERR_NONE;
    if (state == ST_RD_ACCESS && PRDATA != cfg_data) begin
      fail      = 1'b1;
      fail_code = ERR_VERIFY;
    end else if (state == ST_WAIT_BUSY && ccc_busy && cnt == BUSY_LAST) begin
      fail      = 1'b1;
      fail_code = ERR_BUSY_TO;
    end else if (state == ST_WAIT_LOCK && !lock_ok && lock_to) begin
      fail      = 1'b1;
      fail_code = ERR_LOCK_TO;
    end
  end

  fccc_lock_qual #(
    .LOCK_STABLE (LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) u_lock_qual (
    .clk       (PCLK),
    .rst_n     (PRESET_N),
    .lock_async(ccc_lock),
    .clear     (qual_clr),
    .run       (state == ST_WAIT_LOCK),
    .lock_s    (lock_s),
    .lock_ok   (lock_ok),
    .lock_to   (lock_to)
  );

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      cfg_idx    <= '0;
      last_entry <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PLL_ARST_N <= 1'b1;
      ctl_busy   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      lock_lost  <= 1'b0;
    end else begin
      // Flag updates further down override this clear, so new errors and lock loss win.
      if (clr) begin
        err       <= 1'b0;
        err_code  <= ERR_NONE;
        lock_lost <= 1'b0;
      end
      if (restart) begin
        state      <= ST_RST;
        cnt        <= '0;
        cfg_idx    <= '0;
        PLL_ARST_N <= 1'b0;
        ctl_busy   <= 1'b1;
        done       <= 1'b0;
      end else if (to_next) begin
        // cfg_idx advances here so the table lookup has settled before the next WR_SETUP.
        state      <= ST_NEXT;
        PSEL       <= 1'b0;
        PENABLE    <= 1'b0;
        PWRITE     <= 1'b0;
        last_entry <= (cfg_idx == IDX_LAST);
        if (cfg_idx != IDX_LAST) cfg_idx <= cfg_idx + ENTRY_W'(1);
      end else if (fail) begin
        state      <= ST_ERROR;
        err        <= 1'b1;
        err_code   <= fail_code;
        PSEL       <= 1'b0;
        PENABLE    <= 1'b0;
        PWRITE     <= 1'b0;
        PLL_ARST_N <= 1'b1;
        ctl_busy   <= 1'b0;
        done       <= 1'b0;
      end else begin
        case (state)
          ST_RST: begin
            if (cnt == RST_LAST) begin
              cnt     <= '0;
              state   <= ST_WR_SETUP;
              PSEL    <= 1'b1;
              PWRITE  <= 1'b1;
              PENABLE <= 1'b0;
              PADDR   <= cfg_addr;
              PWDATA  <= cfg_data;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_WR_SETUP: begin
            PENABLE <= 1'b1;
            state   <= ST_WR_ACCESS;
          end
          ST_WR_ACCESS: begin
            PWRITE  <= 1'b0;
            PENABLE <= 1'b0;
            state   <= ST_RD_SETUP;
          end
          ST_RD_SETUP: begin
            PENABLE <= 1'b1;
            state   <= ST_RD_ACCESS;
          end
          ST_NEXT: begin
            if (last_entry) begin
              state      <= ST_WAIT_BUSY;
              cnt        <= '0;
              PLL_ARST_N <= 1'b1;
            end else begin
              state  <= ST_WR_SETUP;
              PSEL   <= 1'b1;
              PWRITE <= 1'b1;
              PADDR  <= cfg_addr;
              PWDATA <= cfg_data;
            end
          end
          ST_WAIT_BUSY: begin
            if (!ccc_busy) state <= ST_RELEASE;
            else           cnt   <= cnt + CW'(1);
          end
          ST_RELEASE: begin
            cnt   <= '0;
            state <= ST_WAIT_LOCK;
          end
          ST_WAIT_LOCK: begin
            if (lock_ok) begin
              state    <= ST_LOCKED;
              done     <= 1'b1;
              ctl_busy <= 1'b0;
            end
          end
          ST_LOCKED: begin
            if (!lock_s) begin
              lock_lost <= 1'b1;
              done      <= 1'b0;
              ctl_busy  <= 1'b1;
              state     <= ST_WAIT_LOCK;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/fccc_reconfig_ctrl.md
Name: fccc_reconfig_ctrl

Overview:
- APB-side sequencer that dynamically reconfigures the FCCC/CCC PLL: holds the PLL in reset, writes a table of configuration bytes over the CCC APB port, and optionally reads each byte back to verify it.
- It then releases the PLL, qualifies LOCK, and monitors for loss of lock.
- Sits between system control logic and the FCCC wrapper's PCLK/PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/BUSY/LOCK/PLL_ARST_N pins.

Parameters:
- NUM_ENTRIES, 8, number of config table entries written per sequence (1..2**ENTRY_W)
- ENTRY_W, 3, width of the table index
- RST_CYCLES, 16, PCLK cycles PLL_ARST_N is held low before the first write
- BUSY_TIMEOUT, 256, max cycles to wait for ccc_busy low after the writes
- LOCK_STABLE, 1024, consecutive synchronized-LOCK-high cycles required to declare lock
- LOCK_TIMEOUT, 65536, max cycles from PLL release to qualified lock
- VERIFY, 1, 1 = read back and compare each entry after writing it

Ports:
- PCLK  in  1  single clock for all logic
- PRESET_N  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; ignored unless state is IDLE, LOCKED or ERROR
- clr  in  1  clears err, err_code and lock_lost
- cfg_idx  out  ENTRY_W  index into the external combinational config table
- cfg_word  in  14  table entry: [13:8] APB address, [7:0] data
- PSEL  out  1  APB select to CCC
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB write
- PADDR  out  6  APB address
- PWDATA  out  8  APB write data
- PRDATA  in  8  APB read data
- ccc_busy  in  1  CCC BUSY
- ccc_lock  in  1  CCC LOCK, asynchronous to PCLK
- PLL_ARST_N  out  1  PLL reset, active low
- ctl_busy  out  1  high in every state except IDLE, LOCKED, ERROR
- done  out  1  high only in LOCKED
- err  out  1  sticky error flag
- err_code  out  2  01 verify mismatch, 10 busy timeout, 11 lock timeout
- lock_lost  out  1  sticky; set when lock drops while in LOCKED

Behaviour:
- Clock and reset:
  - One clock PCLK; reset PRESET_N is asynchronous, active-low.
  - On reset: state IDLE; PSEL=PENABLE=PWRITE=0; PADDR=0; PWDATA=0; cfg_idx=0; PLL_ARST_N=1; ctl_busy=0; done=0; err=0; err_code=0; lock_lost=0; all counters 0.
- ccc_lock passes through a 2-flop synchronizer (lock_s) before any use.
- All outputs are registered.
- States and transitions:
  - IDLE: on start -> RST; cfg_idx=0; counter cleared.
  - RST: PLL_ARST_N=0 for RST_CYCLES cycles -> WR_SETUP.
  - WR_SETUP: 1 cycle; PSEL=1, PWRITE=1, PENABLE=0, PADDR=cfg_word[13:8], PWDATA=cfg_word[7:0].
  - WR_ACCESS: 1 cycle; PENABLE=1. The CCC APB has no PREADY, so every transfer is a fixed 2 cycles. Next state is RD_SETUP if VERIFY=1, otherwise NEXT.
  - RD_SETUP: 1 cycle; PSEL=1, PWRITE=0, PENABLE=0, same PADDR.
  - RD_ACCESS: 1 cycle; PENABLE=1. PRDATA is sampled at the end of the cycle.
    - Mismatch with cfg_word[7:0] -> ERROR, err_code=01.
    - Match -> NEXT.
  - NEXT: PSEL=PENABLE=0.
    - cfg_idx==NUM_ENTRIES-1 -> WAIT_BUSY.
    - Otherwise cfg_idx+1 -> WR_SETUP.
    - cfg_idx never wraps.
  - WAIT_BUSY: ccc_busy==0 -> RELEASE. Count reaching BUSY_TIMEOUT -> ERROR, err_code=10.
  - RELEASE: PLL_ARST_N=1; counters cleared -> WAIT_LOCK.
  - WAIT_LOCK:
    - Stable counter increments while lock_s=1 and resets to 0 when lock_s=0.
    - Stable counter reaching LOCK_STABLE -> LOCKED.
    - Timeout counter reaching LOCK_TIMEOUT first -> ERROR, err_code=11.
  - LOCKED: done=1. lock_s=0 sets lock_lost=1 -> WAIT_LOCK with counters cleared; PLL_ARST_N is not touched.
  - ERROR: err=1; PLL_ARST_N=1; APB idle.
- Sequence timing:
  - PLL_ARST_N stays low from RST through NEXT (all APB traffic happens with the PLL in reset).
  - Latency start -> WAIT_BUSY entry = 1 + RST_CYCLES + NUM_ENTRIES*(VERIFY?5:3) cycles.
- Simultaneous events:
  - start in LOCKED or ERROR restarts at RST; err, err_code and lock_lost are left unchanged.
  - clr in the same cycle as a new error: the error wins.
  - clr has priority over lock_lost set only when lock_s is high.
- Counters are saturating and sized by $clog2 of their limit + 1.
- PRESET_N assertion mid-transfer: the APB outputs drop immediately (asynchronous), and PLL_ARST_N returns to 1.

Decomposition:
- Package fccc_reconfig_pkg holds:
  - the state enum;
  - err_code constants ERR_NONE, ERR_VERIFY, ERR_BUSY_TO, ERR_LOCK_TO;
  - CFG_ADDR_W=6 and CFG_DATA_W=8.
- One sub-module, fccc_lock_qual, contains the lock synchronizer, the stable counter and the timeout counter. Its outputs are lock_s, lock_ok and lock_to; its clear input is driven from RELEASE and LOCKED->WAIT_LOCK.

Test Plan:
- Basic write/verify: NUM_ENTRIES=4, VERIFY=1, table {0x00:0x11, 0x01:0x22, 0x02:0x33, 0x03:0x44}, APB slave model echoes writes, busy=0, lock rises 10 cycles after release -> 4 write+read pairs with the correct PADDR/PWDATA; PLL_ARST_N low for exactly 16+20 cycles; done=1 exactly 10+1024+3 sync/pipe cycles after RELEASE; err=0.
- Verify mismatch: model returns 0xFF for address 0x02 -> ERROR after the third RD_ACCESS; err=1, err_code=01; no fourth write occurs; PLL_ARST_N=1.
- Busy timeout: ccc_busy held 1 -> err_code=10 exactly 256 cycles after WAIT_BUSY entry.
- Lock glitches and timeout:
  - lock toggles every 500 cycles -> never locked; err_code=11 at 65536 cycles.
  - lock stable -> done=1.
- Loss of lock: while LOCKED, drop lock for 3 cycles -> lock_lost=1, done=0; done returns after 1024 stable cycles; clr -> lock_lost=0.
- Reset mid-sequence: assert PRESET_N low during WR_ACCESS of entry 2 -> PSEL/PENABLE=0 and PLL_ARST_N=1 immediately; after release, start reruns from cfg_idx=0.
